// File: rtl/hamming_rx_collect.sv
// Receive side of the Hamming(11,7) serial link: samples each bit at mid-period,
// rebuilds the codeword and applies single-error correction before handing it on.
module hamming_rx_collect #(
  parameter int BIT_CYCLES = 16,
  parameter int SAMPLE_AT  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        codein,
  input  logic        sending,
  output logic [10:0] codeout,
  output logic [6:0]  dataout,
  output logic        valid,
  output logic        corrected,
  output logic        uncorr,
  output logic        busy
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_AT);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX   = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [10:0]      sreg_q, sreg_d;
  logic             sending_q;
  logic [10:0]      codeout_q, codeout_d;
  logic [6:0]       dataout_q, dataout_d;
  logic             valid_q, valid_d;
  logic             corrected_q, corrected_d;
  logic             uncorr_q, uncorr_d;

  logic        startCond;
  logic        sampleNow;
  logic        lastSample;
  logic [3:0]  syndrome;
  logic [10:0] fixedWord;
  logic        synCorrectable;
  logic        synUncorrectable;

  assign startCond  = sending && !sending_q;
  assign sampleNow  = (state_q == RECV) && (cnt_q == SAMPLE_CNT);
  assign lastSample = sampleNow && (idx_q == LAST_IDX);

  // Even-parity syndrome: XOR of the positions of every set bit.
  always_comb begin
    syndrome = 4'd0;
    for (int p = 1; p <= 11; p++) begin
      if (sreg_q[p-1]) begin
        syndrome = syndrome ^ 4'(p);
      end
    end
  end

  always_comb begin
    fixedWord        = sreg_q;
    synCorrectable   = (syndrome != 4'd0) && (syndrome <= 4'd11);
    synUncorrectable = (syndrome >= 4'd12);
    if (synCorrectable) begin
      fixedWord[syndrome - 4'd1] = ~sreg_q[syndrome - 4'd1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sreg_q      <= '0;
      sending_q   <= 1'b0;
      codeout_q   <= '0;
      dataout_q   <= '0;
      valid_q     <= 1'b0;
      corrected_q <= 1'b0;
      uncorr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sreg_q      <= sreg_d;
      sending_q   <= sending;
      codeout_q   <= codeout_d;
      dataout_q   <= dataout_d;
      valid_q     <= valid_d;
      corrected_q <= corrected_d;
      uncorr_q    <= uncorr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sreg_d      = sreg_q;
    codeout_d   = codeout_q;
    dataout_d   = dataout_q;
    valid_d     = 1'b0;
    corrected_d = corrected_q;
    uncorr_d    = uncorr_q;

    case (state_q)
      IDLE: begin
        if (startCond) begin
          state_d = RECV;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      RECV: begin
        cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        if (sampleNow) begin
          sreg_d[idx_q] = codein;
        end
        if ((cnt_q == LAST_CNT) && (idx_q < LAST_IDX)) begin
          idx_d = idx_q + 4'd1;
        end
        // Completing the last sample wins over a same-edge drop of sending.
        if (lastSample) begin
          state_d = DECODE;
        end else if (!sending) begin
          state_d = IDLE;
        end
      end

      DECODE: begin
        codeout_d   = fixedWord;
        dataout_d   = {fixedWord[10], fixedWord[9], fixedWord[8], fixedWord[6],
                       fixedWord[5], fixedWord[4], fixedWord[2]};
        corrected_d = synCorrectable;
        uncorr_d    = synUncorrectable;
        valid_d     = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign codeout   = codeout_q;
  assign dataout   = dataout_q;
  assign valid     = valid_q;
  assign corrected = corrected_q;
  assign uncorr    = uncorr_q;
  assign busy      = (state_q == RECV) || (state_q == DECODE);

endmodule

// File: tb/tb_hamming_rx_collect.sv
// Directed bench for hamming_rx_collect: drives serial frames as the serializer
// would and compares decoded results against hand-computed codewords.
module tb_hamming_rx_collect;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        codein = 1'b0;
  logic        sending = 1'b0;
  logic [10:0] codeout;
  logic [6:0]  dataout;
  logic        valid;
  logic        corrected;
  logic        uncorr;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int failures = 0;
  int validCount;
  int validAt;
  logic busyProbe;

  hamming_rx_collect #(
    .BIT_CYCLES(16),
    .SAMPLE_AT (7)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .codein   (codein),
    .sending  (sending),
    .codeout  (codeout),
    .dataout  (dataout),
    .valid    (valid),
    .corrected(corrected),
    .uncorr   (uncorr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_codeout"}, 32'(codeout), 32'h0);
    checkOutput({tag, "_dataout"}, 32'(dataout), 32'h0);
    checkOutput({tag, "_valid"}, 32'(valid), 32'h0);
    checkOutput({tag, "_corrected"}, 32'(corrected), 32'h0);
    checkOutput({tag, "_uncorr"}, 32'(uncorr), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Edge n of the loop is edge T+n, where T is the edge that sees the start condition.
  task automatic applyStimulus(input logic [10:0] word, input int highCycles,
                               input int totalCycles, input int probeAt,
                               input int resetAt);
    int bitIdx;
    validCount = 0;
    validAt    = -1;
    busyProbe  = 1'bx;
    for (int n = 0; n < totalCycles; n++) begin
      bitIdx  = (n / 16 > 10) ? 10 : n / 16;
      sending = (n < highCycles);
      codein  = word[bitIdx];
      if (n == resetAt) begin
        reset = 1'b0;
        #1;
        checkAllZero("reset_mid");
      end
      @(posedge clk);
      #1;
      if (valid) begin
        validCount++;
        validAt = n;
      end
      if (n == probeAt) busyProbe = busy;
    end
    sending = 1'b0;
    codein  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkFrame(input string tag, input logic [10:0] expCode,
                            input logic [6:0] expData, input logic expCorr,
                            input logic expUncorr);
    checkOutput({tag, "_validAt"}, 32'(validAt), 32'd169);
    checkOutput({tag, "_validCount"}, 32'(validCount), 32'd1);
    checkOutput({tag, "_codeout"}, 32'(codeout), 32'(expCode));
    checkOutput({tag, "_dataout"}, 32'(dataout), 32'(expData));
    checkOutput({tag, "_corrected"}, 32'(corrected), 32'(expCorr));
    checkOutput({tag, "_uncorr"}, 32'(uncorr), 32'(expUncorr));
  endtask

  initial begin
    logic [10:0] flipWord;
    $display("[TB] hamming_rx_collect directed run");

    #2 reset = 1'b0;
    #1;
    checkAllZero("por");
    idleCycles(3);
    reset = 1'b1;
    idleCycles(3);

    applyStimulus(11'h52F, 176, 180, 100, -1);
    checkFrame("clean_52F", 11'h52F, 7'h55, 1'b0, 1'b0);
    checkOutput("clean_busy_mid", 32'(busyProbe), 32'h1);
    checkOutput("clean_busy_after", 32'(busy), 32'h0);
    idleCycles(4);

    for (int i = 0; i < 11; i++) begin
      flipWord = 11'h52F ^ (11'h001 << i);
      applyStimulus(flipWord, 176, 180, -1, -1);
      checkFrame($sformatf("flip_pos%0d", i + 1), 11'h52F, 7'h55, 1'b1, 1'b0);
      idleCycles(4);
    end

    applyStimulus(11'h5A7, 176, 180, -1, -1);
    checkFrame("uncorr_5A7", 11'h5A7, 7'h55, 1'b0, 1'b1);
    idleCycles(4);

    applyStimulus(11'h000, 176, 180, -1, -1);
    checkFrame("clean_000", 11'h000, 7'h00, 1'b0, 1'b0);
    idleCycles(4);

    applyStimulus(11'h7FF, 176, 180, -1, -1);
    checkFrame("clean_7FF", 11'h7FF, 7'h7F, 1'b0, 1'b0);
    idleCycles(4);

    applyStimulus(11'h53F, 61, 80, 61, -1);
    checkOutput("abort_validCount", 32'(validCount), 32'd0);
    checkOutput("abort_busy_T61", 32'(busyProbe), 32'h0);
    checkOutput("abort_codeout_hold", 32'(codeout), 32'h7FF);
    checkOutput("abort_dataout_hold", 32'(dataout), 32'h7F);
    idleCycles(4);

    applyStimulus(11'h52F, 176, 180, -1, -1);
    checkFrame("after_abort", 11'h52F, 7'h55, 1'b0, 1'b0);
    idleCycles(4);

    applyStimulus(11'h7FF, 101, 120, -1, 101);
    checkOutput("reset_mid_validCount", 32'(validCount), 32'd0);
    checkAllZero("reset_held");
    reset = 1'b1;
    idleCycles(4);

    applyStimulus(11'h52F, 176, 180, -1, -1);
    checkFrame("after_reset", 11'h52F, 7'h55, 1'b0, 1'b0);
    idleCycles(4);

    applyStimulus(11'h52F, 169, 171, -1, -1);
    checkFrame("b2b_first", 11'h52F, 7'h55, 1'b0, 1'b0);
    applyStimulus(11'h53F, 176, 180, -1, -1);
    checkFrame("b2b_second", 11'h52F, 7'h55, 1'b1, 1'b0);
    idleCycles(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
